// File: rtl/multi_freq_divider_if.sv
// Bundle of per-channel divider controls and outputs shared by the driver and the divider.
// Latency: n/a (signal container only).
// Backpressure: none; all signals are level/strobe, there is no handshake.
// Ports: master drives en/load/load_sel/load_div/load_duty/evt_clr and observes
//        tick/sq/evt_cnt/evt_wrap; slave is the divider side.
interface multi_freq_divider_if #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 8,
    parameter int EVT_W    = 7
);
    logic [CHANNELS-1:0]       en;
    logic                      load;
    logic [CHANNELS-1:0]       load_sel;
    logic [DIV_W-1:0]          load_div;
    logic [DIV_W-1:0]          load_duty;
    logic [CHANNELS-1:0]       evt_clr;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       sq;
    logic [CHANNELS*EVT_W-1:0] evt_cnt;
    logic [CHANNELS-1:0]       evt_wrap;

    modport master (
        output en, load, load_sel, load_div, load_duty, evt_clr,
        input  tick, sq, evt_cnt, evt_wrap
    );

    modport slave (
        input  en, load, load_sel, load_div, load_duty, evt_clr,
        output tick, sq, evt_cnt, evt_wrap
    );
endinterface

// File: rtl/multi_freq_divider.sv
// Multi-channel programmable divider: per channel a 1-cycle tick, a duty-controlled square wave
// and a wrapping tick counter. Latency: outputs are registered, updated on the edge moving ph.
// Backpressure: none; divisor/duty writes are shadowed and take effect at the period boundary.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries en, load, load_sel,
//        load_div, load_duty, evt_clr in and tick, sq, evt_cnt, evt_wrap out.
module multi_freq_divider #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 8,
    parameter int EVT_W    = 7,
    parameter int DEF_DIV  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_freq_divider_if.slave  bus
);
    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] RST_DUTY = DIV_W'(DEF_DIV / 2);
    // Period used when the divisor is programmed to 0.
    localparam logic [DIV_W:0]   FULL_P   = {1'b1, {DIV_W{1'b0}}};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DIV_W-1:0] ph_q;
        logic [DIV_W-1:0] act_div_q, act_duty_q;
        logic [DIV_W-1:0] sh_div_q, sh_duty_q;
        logic             tick_q, sq_q, wrap_q;
        logic [EVT_W-1:0] cnt_q;

        logic             wr;
        logic [DIV_W-1:0] new_div, new_duty, use_duty, ph_nxt;
        logic [DIV_W:0]   period;
        logic             last, fire;

        assign wr = bus.load & bus.load_sel[c];

        // A write on this very edge overrides the shadow so it can be picked up by an
        // immediate copy (disabled) or by a wrap happening on the same edge.
        assign new_div  = wr ? bus.load_div  : sh_div_q;
        assign new_duty = wr ? bus.load_duty : sh_duty_q;

        assign period = (act_div_q == '0) ? FULL_P : {1'b0, act_div_q};
        assign last   = ({1'b0, ph_q} == period - 1'b1);
        assign ph_nxt = last ? '0 : ph_q + 1'b1;
        // The first cycle of a new period already belongs to the new duty setting.
        assign use_duty = last ? new_duty : act_duty_q;
        assign fire     = bus.en[c] & last;

        always_ff @(posedge clk) begin
            if (reset) begin
                ph_q       <= '0;
                act_div_q  <= RST_DIV;
                act_duty_q <= RST_DUTY;
                sh_div_q   <= RST_DIV;
                sh_duty_q  <= RST_DUTY;
                tick_q     <= 1'b0;
                sq_q       <= 1'b0;
                cnt_q      <= '0;
                wrap_q     <= 1'b0;
            end else begin
                if (wr) begin
                    sh_div_q  <= bus.load_div;
                    sh_duty_q <= bus.load_duty;
                end

                if (!bus.en[c]) begin
                    ph_q       <= '0;
                    tick_q     <= 1'b0;
                    sq_q       <= 1'b0;
                    act_div_q  <= new_div;
                    act_duty_q <= new_duty;
                end else begin
                    ph_q   <= ph_nxt;
                    tick_q <= last;
                    sq_q   <= (ph_nxt < use_duty);
                    if (last) begin
                        act_div_q  <= new_div;
                        act_duty_q <= new_duty;
                    end
                end

                // Clear beats a coincident increment; the dropped tick is not counted.
                if (bus.evt_clr[c]) begin
                    cnt_q  <= '0;
                    wrap_q <= 1'b0;
                end else if (fire) begin
                    cnt_q  <= cnt_q + 1'b1;
                    wrap_q <= &cnt_q;
                end else begin
                    wrap_q <= 1'b0;
                end
            end
        end

        assign bus.tick[c]                  = tick_q;
        assign bus.sq[c]                    = sq_q;
        assign bus.evt_wrap[c]              = wrap_q;
        assign bus.evt_cnt[c*EVT_W +: EVT_W] = cnt_q;
    end
endmodule

// File: tb/tb_multi_freq_divider.sv
`timescale 1ns/1ps
module tb_multi_freq_divider;
    localparam int CHANNELS = 2;
    localparam int DIV_W    = 8;
    localparam int EVT_W    = 7;
    localparam int DEF_DIV  = 10;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [1:0]     exp_q[$];   // {tick, sq} expected after each edge
    logic [EVT_W:0] cnt_q[$];   // {evt_wrap, evt_cnt} expected after each edge

    multi_freq_divider_if #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .EVT_W(EVT_W)) bus();

    multi_freq_divider #(
        .CHANNELS(CHANNELS), .DIV_W(DIV_W), .EVT_W(EVT_W), .DEF_DIV(DEF_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {tick, sq} for a channel whose position in its period after the
    // j-th edge is (j+first) mod p: tick at position 0, sq for positions below h.
    task automatic push_run(input int p, input int h, input int first, input int n);
        for (int j = 0; j < n; j++) begin
            int m;
            m = (j + first) % p;
            exp_q.push_back({(m == 0), (m < h)});
        end
    endtask

    task automatic load_ch(input logic [CHANNELS-1:0] sel, input int d, input int h);
        bus.load      = 1'b1;
        bus.load_sel  = sel;
        bus.load_div  = DIV_W'(d);
        bus.load_duty = DIV_W'(h);
        step();
        bus.load      = 1'b0;
        bus.load_sel  = '0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.en        = '0;
        bus.load      = 1'b0;
        bus.load_sel  = '0;
        bus.load_div  = '0;
        bus.load_duty = '0;
        bus.evt_clr   = '0;
        step();
        step();
        total++; if (bus.tick !== 2'b00) begin bad++; $display("FAIL reset_tick got %b want 00", bus.tick); end
        total++; if (bus.sq !== 2'b00) begin bad++; $display("FAIL reset_sq got %b want 00", bus.sq); end
        total++; if (bus.evt_cnt !== '0) begin bad++; $display("FAIL reset_evt_cnt got %h want 0", bus.evt_cnt); end
        total++; if (bus.evt_wrap !== 2'b00) begin bad++; $display("FAIL reset_evt_wrap got %b want 00", bus.evt_wrap); end
        reset = 1'b0;
    endtask

    task automatic test_default_div();
        logic [1:0] e, o;
        bus.en = 2'b01;
        push_run(10, 5, 1, 35);
        for (int j = 0; j < 35; j++) begin
            step();
            e = exp_q.pop_front();
            o = {bus.tick[0], bus.sq[0]};
            total++;
            if (o !== e) begin bad++; $display("FAIL default_div edge%0d tick/sq got %b want %b", j, o, e); end
            total++;
            if ({bus.tick[1], bus.sq[1]} !== 2'b00) begin
                bad++; $display("FAIL idle_ch1 edge%0d tick/sq got %b want 00", j, {bus.tick[1], bus.sq[1]});
            end
        end
        bus.en = '0;
        step();
    endtask

    task automatic test_full_period();
        logic [1:0] e, o;
        load_ch(2'b10, 0, 128);
        bus.en = 2'b10;
        push_run(256, 128, 1, 520);
        for (int j = 0; j < 520; j++) begin
            step();
            e = exp_q.pop_front();
            o = {bus.tick[1], bus.sq[1]};
            total++;
            if (o !== e) begin bad++; $display("FAIL full_period edge%0d tick/sq got %b want %b", j, o, e); end
        end
        bus.en = '0;
        step();
    endtask

    // Two loads mid-period (last wins); the running 10-cycle period must finish intact.
    task automatic test_back_to_back();
        logic [1:0] e, o;
        bus.en = 2'b01;
        push_run(10, 5, 1, 9);
        push_run(4, 2, 0, 21);
        for (int j = 0; j < 30; j++) begin
            if (j == 3) begin
                bus.load = 1'b1; bus.load_sel = 2'b01; bus.load_div = 8'd6; bus.load_duty = 8'd3;
            end else if (j == 4) begin
                bus.load_div = 8'd4; bus.load_duty = 8'd2;
            end else if (j == 5) begin
                bus.load = 1'b0; bus.load_sel = '0;
            end
            step();
            e = exp_q.pop_front();
            o = {bus.tick[0], bus.sq[0]};
            total++;
            if (o !== e) begin bad++; $display("FAIL boundary_load edge%0d tick/sq got %b want %b", j, o, e); end
        end
        bus.en = '0;
        step();
    endtask

    task automatic test_extremes();
        int dv[3] = '{1, 5, 5};
        int hv[3] = '{1, 0, 9};
        logic [1:0] e, o;
        for (int t = 0; t < 3; t++) begin
            bus.en = '0;
            load_ch(2'b01, dv[t], hv[t]);
            bus.en = 2'b01;
            push_run(dv[t], hv[t], 1, 12);
            for (int j = 0; j < 12; j++) begin
                step();
                e = exp_q.pop_front();
                o = {bus.tick[0], bus.sq[0]};
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL extreme D=%0d H=%0d edge%0d tick/sq got %b want %b", dv[t], hv[t], j, o, e);
                end
            end
        end
        bus.en = '0;
        step();
    endtask

    task automatic test_evt_wrap();
        int         exp_cnt;
        logic       exp_w;
        logic [EVT_W:0] e, o;
        bus.evt_clr = 2'b10;
        load_ch(2'b10, 1, 1);
        bus.evt_clr = '0;
        bus.en      = 2'b10;
        exp_cnt     = 0;
        for (int j = 0; j < 330; j++) begin
            // j=316 lands exactly on the second 127->0 step, so clear must suppress the wrap.
            bus.evt_clr = (j == 60 || j == 316) ? 2'b10 : 2'b00;
            if (j == 60 || j == 316) begin
                exp_cnt = 0;
                exp_w   = 1'b0;
            end else begin
                exp_cnt = (exp_cnt + 1) % 128;
                exp_w   = (exp_cnt == 0);
            end
            cnt_q.push_back({exp_w, EVT_W'(exp_cnt)});
            step();
            e = cnt_q.pop_front();
            o = {bus.evt_wrap[1], bus.evt_cnt[EVT_W +: EVT_W]};
            total++;
            if (o !== e) begin bad++; $display("FAIL evt_cnt edge%0d wrap/cnt got %h want %h", j, o, e); end
        end
        bus.evt_clr = '0;
        bus.en      = '0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [1:0] e, o;
        load_ch(2'b01, 7, 3);
        bus.en = 2'b01;
        for (int j = 0; j < 4; j++) step();
        reset = 1'b1;
        step();
        total++; if (bus.tick !== 2'b00) begin bad++; $display("FAIL midreset_tick got %b want 00", bus.tick); end
        total++; if (bus.sq !== 2'b00) begin bad++; $display("FAIL midreset_sq got %b want 00", bus.sq); end
        total++; if (bus.evt_cnt !== '0) begin bad++; $display("FAIL midreset_evt_cnt got %h want 0", bus.evt_cnt); end
        total++; if (bus.evt_wrap !== 2'b00) begin bad++; $display("FAIL midreset_evt_wrap got %b want 00", bus.evt_wrap); end
        reset = 1'b0;
        push_run(10, 5, 1, 25);
        for (int j = 0; j < 25; j++) begin
            step();
            e = exp_q.pop_front();
            o = {bus.tick[0], bus.sq[0]};
            total++;
            if (o !== e) begin bad++; $display("FAIL restart edge%0d tick/sq got %b want %b", j, o, e); end
        end
        bus.en = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_full_period();
        test_back_to_back();
        test_extremes();
        test_evt_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
